// File: rtl/forwarding_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_control_unit
// Purpose  : Operand-forwarding select generation for the dual-lane
//            (Branch + Memory) core. Tracks destination tags through
//            EX -> P1 (EX/MEM) -> P2 (MEM/WB). It compares the decode-stage
//            sources against those tags and registers a 3-bit select per EX
//            operand. It also raises the load-use stall.
// Ports    : clk, rst_n                      clock, async active-low reset
//            id_valid                         decode bundle valid
//            id_b_rd/we, id_m_rd/we           lane destinations / write enables
//            id_m_is_load                     Memory lane is a load
//            id_b_rs1/rs2, id_m_rs1/rs2       decode sources
//            hold_i, flush_i                  freeze / kill ID+EX
//            fwd_b_rs1/rs2, fwd_m_rs1/rs2     registered EX operand selects
//            load_use_stall_o                 freeze IF/ID, bubble EX
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_control_unit #(
  parameter int REG_AW = 5,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_b_rd,
  input  logic [REG_AW-1:0] id_m_rd,
  input  logic              id_b_we,
  input  logic              id_m_we,
  input  logic              id_m_is_load,
  input  logic [REG_AW-1:0] id_b_rs1,
  input  logic [REG_AW-1:0] id_b_rs2,
  input  logic [REG_AW-1:0] id_m_rs1,
  input  logic [REG_AW-1:0] id_m_rs2,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [MODE_W-1:0] fwd_b_rs1,
  output logic [MODE_W-1:0] fwd_b_rs2,
  output logic [MODE_W-1:0] fwd_m_rs1,
  output logic [MODE_W-1:0] fwd_m_rs2,
  output logic              load_use_stall_o
);

  localparam logic [MODE_W-1:0] c_sel_rf   = MODE_W'(0);
  localparam logic [MODE_W-1:0] c_sel_b_p1 = MODE_W'(1);
  localparam logic [MODE_W-1:0] c_sel_m_p1 = MODE_W'(2);
  localparam logic [MODE_W-1:0] c_sel_b_p2 = MODE_W'(3);
  localparam logic [MODE_W-1:0] c_sel_m_p2 = MODE_W'(4);
  localparam logic [MODE_W-1:0] c_sel_b_p3 = MODE_W'(5);
  localparam logic [MODE_W-1:0] c_sel_m_p3 = MODE_W'(6);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
  } tag_t;

  // The WB hold latch (P3) tag is not stored: a producer that has reached P3
  // before the edge has already written the register file, so it can never
  // be a forwarding source. For the same reason, is_load only matters while
  // the load sits in EX, so it is kept only for the EX Memory-lane slot.
  tag_t r_ex_b, r_ex_m, r_p1_b, r_p1_m, r_p2_b, r_p2_m;
  logic r_ex_m_ld;

  logic [MODE_W-1:0] r_fwd_b_rs1, r_fwd_b_rs2, r_fwd_m_rs1, r_fwd_m_rs2;
  logic [MODE_W-1:0] w_sel_b_rs1, w_sel_b_rs2, w_sel_m_rs1, w_sel_m_rs2;
  logic              w_stall;
  logic              w_ld_hit;

  function automatic logic f_hit(input tag_t t, input logic [REG_AW-1:0] src);
    return t.v && t.we && (t.rd != '0) && (t.rd == src);
  endfunction

  // Youngest producer wins; within a stage the Memory slot is younger.
  function automatic logic [MODE_W-1:0] f_sel(
    input logic [REG_AW-1:0] src,
    input tag_t ex_b, input tag_t ex_m,
    input tag_t p1_b, input tag_t p1_m,
    input tag_t p2_b, input tag_t p2_m
  );
    logic [MODE_W-1:0] sel;
    sel = c_sel_rf;
    if      (f_hit(ex_m, src)) sel = c_sel_m_p1;
    else if (f_hit(ex_b, src)) sel = c_sel_b_p1;
    else if (f_hit(p1_m, src)) sel = c_sel_m_p2;
    else if (f_hit(p1_b, src)) sel = c_sel_b_p2;
    else if (f_hit(p2_m, src)) sel = c_sel_m_p3;
    else if (f_hit(p2_b, src)) sel = c_sel_b_p3;
    return sel;
  endfunction

  always_comb begin
    w_sel_b_rs1 = f_sel(id_b_rs1, r_ex_b, r_ex_m, r_p1_b, r_p1_m, r_p2_b, r_p2_m);
    w_sel_b_rs2 = f_sel(id_b_rs2, r_ex_b, r_ex_m, r_p1_b, r_p1_m, r_p2_b, r_p2_m);
    w_sel_m_rs1 = f_sel(id_m_rs1, r_ex_b, r_ex_m, r_p1_b, r_p1_m, r_p2_b, r_p2_m);
    w_sel_m_rs2 = f_sel(id_m_rs2, r_ex_b, r_ex_m, r_p1_b, r_p1_m, r_p2_b, r_p2_m);
  end

  // A load in EX cannot supply its data until it reaches P1, so a dependent
  // decode bundle must wait one cycle.
  assign w_ld_hit = (id_b_rs1 == r_ex_m.rd) || (id_b_rs2 == r_ex_m.rd) ||
                    (id_m_rs1 == r_ex_m.rd) || (id_m_rs2 == r_ex_m.rd);
  assign w_stall  = id_valid && r_ex_m.v && r_ex_m_ld && r_ex_m.we &&
                    (r_ex_m.rd != '0) && w_ld_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_b      <= '0;
      r_ex_m      <= '0;
      r_ex_m_ld   <= 1'b0;
      r_p1_b      <= '0;
      r_p1_m      <= '0;
      r_p2_b      <= '0;
      r_p2_m      <= '0;
      r_fwd_b_rs1 <= c_sel_rf;
      r_fwd_b_rs2 <= c_sel_rf;
      r_fwd_m_rs1 <= c_sel_rf;
      r_fwd_m_rs2 <= c_sel_rf;
    end else if (flush_i || (!hold_i && w_stall)) begin
      // Flush and load-use both put a bubble into EX while the older
      // stages keep draining.
      r_ex_b      <= '0;
      r_ex_m      <= '0;
      r_ex_m_ld   <= 1'b0;
      r_p1_b      <= r_ex_b;
      r_p1_m      <= r_ex_m;
      r_p2_b      <= r_p1_b;
      r_p2_m      <= r_p1_m;
      r_fwd_b_rs1 <= c_sel_rf;
      r_fwd_b_rs2 <= c_sel_rf;
      r_fwd_m_rs1 <= c_sel_rf;
      r_fwd_m_rs2 <= c_sel_rf;
    end else if (!hold_i) begin
      r_ex_b      <= '{v: id_valid, rd: id_b_rd, we: id_b_we};
      r_ex_m      <= '{v: id_valid, rd: id_m_rd, we: id_m_we};
      r_ex_m_ld   <= id_m_is_load;
      r_p1_b      <= r_ex_b;
      r_p1_m      <= r_ex_m;
      r_p2_b      <= r_p1_b;
      r_p2_m      <= r_p1_m;
      r_fwd_b_rs1 <= id_valid ? w_sel_b_rs1 : c_sel_rf;
      r_fwd_b_rs2 <= id_valid ? w_sel_b_rs2 : c_sel_rf;
      r_fwd_m_rs1 <= id_valid ? w_sel_m_rs1 : c_sel_rf;
      r_fwd_m_rs2 <= id_valid ? w_sel_m_rs2 : c_sel_rf;
    end
  end

  assign fwd_b_rs1        = r_fwd_b_rs1;
  assign fwd_b_rs2        = r_fwd_b_rs2;
  assign fwd_m_rs1        = r_fwd_m_rs1;
  assign fwd_m_rs2        = r_fwd_m_rs2;
  assign load_use_stall_o = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_forwarding_control_unit
// Purpose  : Directed self-checking bench for forwarding_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_forwarding_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_b_rd, id_m_rd;
  logic       id_b_we, id_m_we, id_m_is_load;
  logic [4:0] id_b_rs1, id_b_rs2, id_m_rs1, id_m_rs2;
  logic       hold_i, flush_i;
  logic [2:0] fwd_b_rs1, fwd_b_rs2, fwd_m_rs1, fwd_m_rs2;
  logic       load_use_stall_o;

  int errors = 0;
  int checks = 0;

  forwarding_control_unit #(.REG_AW(5), .MODE_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_b_rd          (id_b_rd),
    .id_m_rd          (id_m_rd),
    .id_b_we          (id_b_we),
    .id_m_we          (id_m_we),
    .id_m_is_load     (id_m_is_load),
    .id_b_rs1         (id_b_rs1),
    .id_b_rs2         (id_b_rs2),
    .id_m_rs1         (id_m_rs1),
    .id_m_rs2         (id_m_rs2),
    .hold_i           (hold_i),
    .flush_i          (flush_i),
    .fwd_b_rs1        (fwd_b_rs1),
    .fwd_b_rs2        (fwd_b_rs2),
    .fwd_m_rs1        (fwd_m_rs1),
    .fwd_m_rs2        (fwd_m_rs2),
    .load_use_stall_o (load_use_stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v,
                        input logic [4:0] brd, input logic bwe,
                        input logic [4:0] mrd, input logic mwe, input logic mld,
                        input logic [4:0] brs1, input logic [4:0] brs2,
                        input logic [4:0] mrs1, input logic [4:0] mrs2);
    id_valid = v;   id_b_rd = brd;  id_b_we = bwe;
    id_m_rd = mrd;  id_m_we = mwe;  id_m_is_load = mld;
    id_b_rs1 = brs1; id_b_rs2 = brs2; id_m_rs1 = mrs1; id_m_rs2 = mrs2;
  endtask

  task automatic idle(input int n);
    set_id(0, 0,0, 0,0,0, 0,0,0,0);
    repeat (n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".b_rs1"}, {5'd0, fwd_b_rs1}, 8'd0);
    check({tag, ".b_rs2"}, {5'd0, fwd_b_rs2}, 8'd0);
    check({tag, ".m_rs1"}, {5'd0, fwd_m_rs1}, 8'd0);
    check({tag, ".m_rs2"}, {5'd0, fwd_m_rs2}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    set_id(0, 0,0, 0,0,0, 0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset.stall", {7'd0, load_use_stall_o}, 8'd0);
    rst_n = 1'b1;
    tick();

    // 1. Reset mid-operation (including mid-stall)
    set_id(1, 0,0, 5,1,0, 0,0,0,0); tick();          // EX: Memory writes x5
    set_id(1, 0,0, 9,1,1, 5,0,0,0); tick();          // reads x5; load x9 enters EX
    check("t1.pre_b_rs1", {5'd0, fwd_b_rs1}, 8'b010);
    set_id(1, 0,0, 0,0,0, 0,9,0,0); #1;
    check("t1.pre_stall", {7'd0, load_use_stall_o}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t1.async");
    check("t1.async_stall", {7'd0, load_use_stall_o}, 8'd0);
    #2 rst_n = 1'b1;
    idle(1);

    // 2a. Back-to-back Branch x5 -> Memory rs1
    set_id(1, 5,1, 0,0,0, 0,0,0,0); tick();
    set_id(1, 0,0, 0,0,0, 0,0,5,0); tick();
    check("t2.m_rs1_b2b", {5'd0, fwd_m_rs1}, 8'b001);
    check("t2.m_rs2_b2b", {5'd0, fwd_m_rs2}, 8'b000);
    idle(4);

    // 2b. One bubble between producer and rs2 consumer
    set_id(1, 5,1, 0,0,0, 0,0,0,0); tick();
    idle(1);
    set_id(1, 0,0, 0,0,0, 0,0,0,5); tick();
    check("t2.m_rs2_gap", {5'd0, fwd_m_rs2}, 8'b011);
    idle(4);

    // 3. Both lanes write x7: Memory lane is younger
    set_id(1, 7,1, 7,1,0, 0,0,0,0); tick();
    set_id(1, 0,0, 0,0,0, 7,0,0,0); tick();
    check("t3.same_stage", {5'd0, fwd_b_rs1}, 8'b010);
    idle(4);

    // 4. Load-use on x9
    set_id(1, 0,0, 9,1,1, 0,0,0,0); tick();
    set_id(1, 0,0, 0,0,0, 0,9,0,0); #1;
    check("t4.stall_on", {7'd0, load_use_stall_o}, 8'd1);
    tick();
    check("t4.stall_off", {7'd0, load_use_stall_o}, 8'd0);
    check_all_zero("t4.stall_cycle");
    tick();
    check("t4.b_rs2_load", {5'd0, fwd_b_rs2}, 8'b100);
    check("t4.no_restall", {7'd0, load_use_stall_o}, 8'd0);
    idle(4);

    // 5a. x0 never forwards
    set_id(1, 0,1, 0,1,0, 0,0,0,0); tick();
    set_id(1, 0,0, 0,0,0, 0,0,0,0); tick();
    check("t5.x0_b", {5'd0, fwd_b_rs1}, 8'b000);
    check("t5.x0_m", {5'd0, fwd_m_rs1}, 8'b000);
    idle(4);

    // 5b. x3 at P2 (Memory) and at EX (Branch): youngest wins
    set_id(1, 0,0, 3,1,0, 0,0,0,0); tick();
    idle(1);
    set_id(1, 3,1, 0,0,0, 0,0,0,0); tick();
    set_id(1, 0,0, 0,0,0, 0,0,3,0); tick();
    check("t5.youngest", {5'd0, fwd_m_rs1}, 8'b001);
    idle(4);

    // 5c. Producer at P2 -> Branch P3; one bundle later (P3) -> register file
    set_id(1, 6,1, 0,0,0, 0,0,0,0); tick();
    idle(2);
    set_id(1, 0,0, 0,0,0, 6,0,0,0); tick();
    check("t5.p2_age", {5'd0, fwd_b_rs1}, 8'b101);
    tick();
    check("t5.p3_age", {5'd0, fwd_b_rs1}, 8'b000);
    idle(4);

    // 6a. Flush (with hold) while EX writes x4
    set_id(1, 0,0, 10,1,0, 0,0,0,0); tick();
    set_id(1, 4,1, 0,0,0, 10,0,0,0); tick();
    check("t6.pre_flush", {5'd0, fwd_b_rs1}, 8'b010);
    flush_i = 1'b1; hold_i = 1'b1;
    set_id(1, 0,0, 12,1,0, 0,0,0,0); tick();
    check_all_zero("t6.flush");
    flush_i = 1'b0; hold_i = 1'b0;
    set_id(1, 0,0, 0,0,0, 0,0,4,12); tick();
    check("t6.x4_not_ex", {7'd0, (fwd_m_rs1 == 3'b001)}, 8'd0);
    check("t6.killed_id", {5'd0, fwd_m_rs2}, 8'b000);
    idle(4);

    // 6b. Hold freezes selects and tags for 3 cycles
    set_id(1, 0,0, 13,1,0, 0,0,0,0); tick();
    set_id(1, 0,0, 0,0,0, 13,0,0,0); tick();
    check("t6.pre_hold", {5'd0, fwd_b_rs1}, 8'b010);
    hold_i = 1'b1;
    set_id(1, 0,0, 0,0,0, 0,13,0,0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6.hold_b_rs1", {5'd0, fwd_b_rs1}, 8'b010);
      check("t6.hold_b_rs2", {5'd0, fwd_b_rs2}, 8'b000);
    end
    hold_i = 1'b0;
    tick();
    check("t6.release_b_rs2", {5'd0, fwd_b_rs2}, 8'b100);
    check("t6.release_b_rs1", {5'd0, fwd_b_rs1}, 8'b000);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
